// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_pkg
//  Purpose  : Shared next-PC select encoding and instruction size for pc_unit
//  Revision : 1.0
// ============================================================================
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SEQ = 2'd0,
        PC_BR  = 2'd1,
        PC_J   = 2'd2,
        PC_REG = 2'd3
    } pc_src_e;

    localparam int unsigned INSTR_BYTES = 4;

endpackage
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
//  Module   : pc_ras
//  Purpose  : Circular return-address stack with overflow/underflow flags
//  Revision : 1.0
// ============================================================================
module pc_ras #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_unf;

    logic [PTR_W-1:0] w_top_idx;
    logic [PTR_W-1:0] w_wr_idx;

    // r_ptr names the next free slot; the top entry sits just below it.
    assign w_top_idx = r_ptr - PTR_W'(1);
    assign top       = r_mem[w_top_idx];
    assign empty     = (r_cnt == '0);
    assign full      = (r_cnt == CNT_W'(RAS_DEPTH));
    assign ovf       = r_ovf;
    assign unf       = r_unf;

    // A push paired with a pop on a live stack replaces the top in place.
    always_comb begin
        w_wr_idx = r_ptr;
        if (push && pop && !empty) begin
            w_wr_idx = w_top_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_unf <= pop && empty;
            if (push && pop) begin
                if (empty) begin
                    r_ptr <= r_ptr + PTR_W'(1);
                    r_cnt <= CNT_W'(1);
                end
            end else if (push) begin
                r_ptr <= r_ptr + PTR_W'(1);
                if (full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (pop && !empty) begin
                r_ptr <= w_top_idx;
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit
//  Purpose  : Program counter with next-PC mux and return-address stack
//  Revision : 1.0
// ============================================================================
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCWre,
    input  logic [1:0]       PCSrc,
    input  logic [WIDTH-1:0] br_off,
    input  logic [25:0]      j_idx,
    input  logic [WIDTH-1:0] rs_val,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] PCOut,
    output logic [WIDTH-1:0] PCPlus4,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_unf
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_plus4;
    logic [WIDTH-1:0] w_jump;
    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_push;
    logic             w_pop;
    pc_src_e          w_src;

    assign w_plus4 = r_pc + WIDTH'(INSTR_BYTES);
    assign w_src   = pc_src_e'(PCSrc);
    assign w_push  = PCWre && call;
    assign w_pop   = PCWre && ret;
    assign PCOut   = r_pc;
    assign PCPlus4 = w_plus4;

    if (WIDTH > 28) begin : g_jump_wide
        assign w_jump = {w_plus4[WIDTH-1:28], j_idx, 2'b00};
    end else begin : g_jump_narrow
        assign w_jump = {j_idx, 2'b00};
    end

    // A return overrides PCSrc; on an empty stack it falls back to rs_val.
    always_comb begin
        w_target = w_plus4;
        if (ret) begin
            w_target = ras_empty ? rs_val : w_ras_top;
        end else begin
            case (w_src)
                PC_SEQ:  w_target = w_plus4;
                PC_BR:   w_target = w_plus4 + (br_off << 2);
                PC_J:    w_target = w_jump;
                PC_REG:  w_target = rs_val;
                default: w_target = w_plus4;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_VEC;
        end else if (PCWre) begin
            r_pc <= w_target;
        end
    end

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_plus4),
        .top       (w_ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .ovf       (ras_ovf),
        .unf       (ras_unf)
    );

endmodule
`default_nettype wire
